// File: rtl/uart_fifo.sv
// Memory-mapped UART with programmable baud divisor, TX/RX FIFOs, sticky error flags,
// level interrupt and a free-running millisecond counter.

module uart_fifo_buf #(
    parameter int DEPTH = 16
) (
    input  logic                     clk_48m,
    input  logic                     rstn,
    input  logic                     push,
    input  logic                     pop,
    input  logic [7:0]               din,
    output logic [7:0]               dout,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (level == (AW+1)'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = empty ? 8'h00 : mem[rd_ptr];

    always_ff @(posedge clk_48m) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   level <= level + (AW+1)'(1);
                2'b01:   level <= level - (AW+1)'(1);
                default: level <= level;
            endcase
        end
    end

    // NOTE: storage has no reset; only pointers and level define what is valid.
    always_ff @(posedge clk_48m) begin
        if (do_push) mem[wr_ptr] <= din;
    end
endmodule

module uart_fifo #(
    parameter int CLK_HZ   = 48000000,
    parameter int BAUD_DIV = 48,
    parameter int TX_DEPTH = 16,
    parameter int RX_DEPTH = 16
) (
    input  logic        clk_48m,
    input  logic        rstn,
    input  logic        m_sel,
    input  logic [3:0]  m_addr,
    input  logic [31:0] m_data_i,
    output logic [31:0] m_data_o,
    input  logic        m_rd,
    input  logic        m_wr,
    output logic        m_intr_o,
    output logic        TXD,
    input  logic        RXD
);
    localparam logic [31:0] MS_LAST = 32'(CLK_HZ / 1000 - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_t;

    logic [15:0] baud;
    logic [31:0] ms_count, ms_presc;
    logic        rx_overrun, frame_err, tx_drop;

    logic data_wr, status_wr, baud_wr;
    assign data_wr   = m_sel & m_wr & (m_addr == 4'd0);
    assign status_wr = m_sel & m_wr & (m_addr == 4'd1);
    assign baud_wr   = m_sel & m_wr & (m_addr == 4'd3);

    logic unused_inputs;
    assign unused_inputs = ^{m_rd, m_data_i[31:16]};

    // FIFOs
    logic [7:0] tx_head, rx_head, rx_byte;
    logic [$clog2(TX_DEPTH):0] tx_level;
    logic [$clog2(RX_DEPTH):0] rx_level;
    logic tx_full, tx_empty, tx_pop, rx_full, rx_empty, rx_push;

    uart_fifo_buf #(.DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk_48m(clk_48m), .rstn(rstn), .push(data_wr), .pop(tx_pop), .din(m_data_i[7:0]),
        .dout(tx_head), .level(tx_level), .full(tx_full), .empty(tx_empty)
    );

    uart_fifo_buf #(.DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk_48m(clk_48m), .rstn(rstn), .push(rx_push), .pop(status_wr & m_data_i[0]), .din(rx_byte),
        .dout(rx_head), .level(rx_level), .full(rx_full), .empty(rx_empty)
    );

    // Transmitter: every bit, including start and stop, lasts tx_div cycles.
    uart_state_t tx_state;
    logic [15:0] tx_div, tx_cnt;
    logic [7:0]  tx_shift;
    logic [2:0]  tx_bit;
    logic        tx_bit_end;

    assign tx_bit_end = (tx_cnt == tx_div - 16'd1);
    assign tx_pop     = ~tx_empty & ((tx_state == S_IDLE) | ((tx_state == S_STOP) & tx_bit_end));

    always_ff @(posedge clk_48m) begin
        if (!rstn) begin
            tx_state <= S_IDLE;
            TXD      <= 1'b1;
            tx_div   <= 16'(BAUD_DIV);
            tx_cnt   <= '0;
            tx_shift <= '0;
            tx_bit   <= '0;
        end else begin
            tx_cnt <= tx_bit_end ? 16'd0 : tx_cnt + 16'd1;
            case (tx_state)
                S_IDLE: begin
                    tx_cnt <= '0;
                    if (!tx_empty) begin
                        tx_state <= S_START;
                        TXD      <= 1'b0;
                        tx_shift <= tx_head;
                        tx_div   <= baud;
                    end
                end
                S_START: if (tx_bit_end) begin
                    tx_state <= S_DATA;
                    TXD      <= tx_shift[0];
                    tx_bit   <= '0;
                end
                S_DATA: if (tx_bit_end) begin
                    if (tx_bit == 3'd7) begin
                        tx_state <= S_STOP;
                        TXD      <= 1'b1;
                    end else begin
                        TXD      <= tx_shift[1];
                        tx_shift <= tx_shift >> 1;
                        tx_bit   <= tx_bit + 3'd1;
                    end
                end
                S_STOP: if (tx_bit_end) begin
                    if (!tx_empty) begin
                        tx_state <= S_START;
                        TXD      <= 1'b0;
                        tx_shift <= tx_head;
                        tx_div   <= baud;
                    end else begin
                        tx_state <= S_IDLE;
                    end
                end
                default: tx_state <= S_IDLE;
            endcase
        end
    end

    // Receiver: 2-flop synchroniser plus one delayed copy for falling-edge detection.
    logic rxd_meta, rxd_sync, rxd_prev;
    uart_state_t rx_state;
    logic [15:0] rx_div, rx_cnt;
    logic [2:0]  rx_bit;
    logic        rx_err_wait, rx_bit_end, rx_half_end, rx_stop_sample;

    assign rx_bit_end     = (rx_cnt == rx_div - 16'd1);
    assign rx_half_end    = (rx_cnt == {1'b0, rx_div[15:1]} - 16'd1);
    assign rx_stop_sample = (rx_state == S_STOP) & ~rx_err_wait & rx_bit_end;
    assign rx_push        = rx_stop_sample & rxd_sync;

    always_ff @(posedge clk_48m) begin
        if (!rstn) begin
            {rxd_meta, rxd_sync, rxd_prev} <= 3'b111;
            rx_state    <= S_IDLE;
            rx_div      <= 16'(BAUD_DIV);
            rx_cnt      <= '0;
            rx_bit      <= '0;
            rx_byte     <= '0;
            rx_err_wait <= 1'b0;
        end else begin
            rxd_meta <= RXD;
            rxd_sync <= rxd_meta;
            rxd_prev <= rxd_sync;
            rx_cnt   <= rx_cnt + 16'd1;
            case (rx_state)
                S_IDLE: begin
                    rx_cnt <= '0;
                    if (rxd_prev & ~rxd_sync) begin
                        rx_state <= S_START;
                        rx_div   <= baud;
                    end
                end
                S_START: if (rx_half_end) begin
                    rx_cnt   <= '0;
                    rx_bit   <= '0;
                    rx_state <= rxd_sync ? S_IDLE : S_DATA;
                end
                S_DATA: if (rx_bit_end) begin
                    rx_cnt  <= '0;
                    rx_byte <= {rxd_sync, rx_byte[7:1]};
                    rx_bit  <= rx_bit + 3'd1;
                    if (rx_bit == 3'd7) rx_state <= S_STOP;
                end
                S_STOP: begin
                    if (rx_err_wait || rx_bit_end) rx_cnt <= '0;
                    if (rx_err_wait) begin
                        if (rxd_sync) begin
                            rx_err_wait <= 1'b0;
                            rx_state    <= S_IDLE;
                        end
                    end else if (rx_bit_end) begin
                        if (rxd_sync) rx_state    <= S_IDLE;
                        else          rx_err_wait <= 1'b1;
                    end
                end
                default: rx_state <= S_IDLE;
            endcase
        end
    end

    // Registers, sticky flags (a set in the same cycle as a clear wins) and the ms timer.
    always_ff @(posedge clk_48m) begin
        if (!rstn) begin
            baud       <= 16'(BAUD_DIV);
            ms_count   <= '0;
            ms_presc   <= '0;
            rx_overrun <= 1'b0;
            frame_err  <= 1'b0;
            tx_drop    <= 1'b0;
        end else begin
            if (baud_wr) baud <= (m_data_i[15:0] < 16'd4) ? 16'd4 : m_data_i[15:0];
            if (ms_presc == MS_LAST) begin
                ms_presc <= '0;
                ms_count <= ms_count + 32'd1;
            end else begin
                ms_presc <= ms_presc + 32'd1;
            end
            if (status_wr && m_data_i[4]) rx_overrun <= 1'b0;
            if (status_wr && m_data_i[5]) frame_err  <= 1'b0;
            if (status_wr && m_data_i[6]) tx_drop    <= 1'b0;
            if (rx_push && rx_full)        rx_overrun <= 1'b1;
            if (rx_stop_sample && !rxd_sync) frame_err <= 1'b1;
            if (data_wr && tx_full)        tx_drop    <= 1'b1;
        end
    end

    logic tx_idle, rx_valid;
    assign tx_idle  = (tx_state == S_IDLE) & tx_empty;
    assign rx_valid = ~rx_empty;
    assign m_intr_o = rx_valid | rx_overrun | frame_err;

    // NOTE: default assignment first so the read mux never infers a latch.
    always_comb begin
        m_data_o = '0;
        case (m_addr)
            4'd0: m_data_o = {23'b0, rx_valid, rx_head};
            4'd1: m_data_o = {8'b0, 8'(tx_level), 8'(rx_level), 1'b0, tx_drop, frame_err,
                              rx_overrun, rx_full, tx_full, rx_valid, tx_idle};
            4'd2: m_data_o = ms_count;
            4'd3: m_data_o = {16'b0, baud};
            default: m_data_o = '0;
        endcase
    end
endmodule

// File: tb/tb_uart_fifo.sv
// Directed-plus-random bench for uart_fifo: TXD is traced per cycle and compared with ideal
// 8N1 frames; RX bytes and flags are predicted by a queue-based model.

module tb_uart_fifo;
    localparam int DIV   = 48;
    localparam int DEPTH = 16;
    localparam int MAXC  = 100000;

    logic        clk_48m = 1'b0;
    logic        rstn = 1'b0;
    logic        m_sel = 1'b0, m_rd = 1'b0, m_wr = 1'b0;
    logic [3:0]  m_addr = '0;
    logic [31:0] m_data_i = '0;
    logic [31:0] m_data_o;
    logic        m_intr_o, TXD;
    logic        RXD = 1'b1;

    uart_fifo #(.CLK_HZ(48000000), .BAUD_DIV(DIV), .TX_DEPTH(DEPTH), .RX_DEPTH(DEPTH)) dut (
        .clk_48m(clk_48m), .rstn(rstn), .m_sel(m_sel), .m_addr(m_addr), .m_data_i(m_data_i),
        .m_data_o(m_data_o), .m_rd(m_rd), .m_wr(m_wr), .m_intr_o(m_intr_o), .TXD(TXD), .RXD(RXD)
    );

    always #5 clk_48m = ~clk_48m;

    // cyc = number of rising edges so far; txd_tr[c] = TXD as left by edge c.
    int   cyc = 0;
    logic txd_tr [MAXC];
    always @(posedge clk_48m) cyc <= cyc + 1;
    always @(negedge clk_48m) if (cyc < MAXC) txd_tr[cyc] = TXD;

    int checks = 0, failures = 0;

    // Reference model state
    logic [7:0] tx_q[$], rx_q[$], sent[$];
    bit ovr = 0, ferr = 0, drop = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk_48m);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk_48m);
    endtask

    task automatic bus_wr(input logic [3:0] a, input logic [31:0] d, output int wr_edge);
        @(negedge clk_48m);
        m_sel = 1'b1; m_wr = 1'b1; m_addr = a; m_data_i = d;
        @(negedge clk_48m);
        wr_edge = cyc;
        m_sel = 1'b0; m_wr = 1'b0;
    endtask

    task automatic bus_rd(input logic [3:0] a, output logic [31:0] d);
        m_sel = 1'b1; m_rd = 1'b1; m_addr = a;
        #1;
        d = m_data_o;
        m_sel = 1'b0; m_rd = 1'b0;
    endtask

    function automatic logic [31:0] exp_status(input bit idle);
        logic [31:0] s = '0;
        s[0] = idle;
        s[1] = (rx_q.size() > 0);
        s[2] = (tx_q.size() == DEPTH);
        s[3] = (rx_q.size() == DEPTH);
        s[4] = ovr;
        s[5] = ferr;
        s[6] = drop;
        s[15:8]  = 8'(rx_q.size());
        s[23:16] = 8'(tx_q.size());
        return s;
    endfunction

    function automatic logic [31:0] exp_data();
        return (rx_q.size() > 0) ? {23'b0, 1'b1, rx_q[0]} : 32'h0;
    endfunction

    function automatic logic [31:0] exp_intr();
        return {31'b0, (rx_q.size() > 0) | ovr | ferr};
    endfunction

    // Number of cycles where the traced TXD differs from an ideal frame starting at edge s.
    function automatic int frame_bad(input int s, input logic [7:0] b, input int d);
        int bad = 0;
        for (int i = 0; i < 10 * d; i++) begin
            int k = i / d;
            logic e = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
            if (txd_tr[s+i] !== e) bad++;
        end
        return bad;
    endfunction

    // Drive one frame on RXD; DATA is sampled 4 cycles after the stop-bit midpoint.
    task automatic send_rx(input logic [7:0] b, input int d, input logic stop_bit, output logic [31:0] rd);
        RXD = 1'b0;
        tick(d);
        for (int i = 0; i < 8; i++) begin
            RXD = b[i];
            tick(d);
        end
        RXD = stop_bit;
        tick(d / 2 + 4);
        bus_rd(4'd0, rd);
        tick(d - d / 2 - 4);
        RXD = 1'b1;
        tick(2 * d);
        if (stop_bit) begin
            if (rx_q.size() < DEPTH) rx_q.push_back(b);
            else ovr = 1;
        end else begin
            ferr = 1;
        end
    endtask

    initial begin
        logic [31:0] rd;
        logic [7:0]  b;
        int n, n0, dummy, rel;

        tick(3);
        rstn = 1'b1;
        rel = cyc + 1;
        bus_rd(4'd1, rd); check("reset_status", rd, 32'h1);
        bus_rd(4'd0, rd); check("reset_data", rd, 32'h0);
        bus_rd(4'd2, rd); check("reset_ms", rd, 32'h0);
        bus_rd(4'd3, rd); check("reset_baud", rd, 32'(DIV));
        bus_rd(4'd7, rd); check("reset_unmapped", rd, 32'h0);
        check("reset_txd", {31'b0, TXD}, 32'h1);
        check("reset_intr", {31'b0, m_intr_o}, exp_intr());

        // Single byte 0x55
        bus_wr(4'd0, 32'h55, n);
        wait_until(n + 10 * DIV);
        bus_rd(4'd1, rd); check("tx55_busy_last_cycle", rd, exp_status(0));
        tick(1);
        bus_rd(4'd1, rd); check("tx55_idle_after_stop", rd, exp_status(1));
        check("tx55_idle_before_start", {31'b0, txd_tr[n]}, 32'h1);
        check("tx55_frame", 32'(frame_bad(n + 1, 8'h55, DIV)), 32'h0);

        // 17 writes behind a busy line: the last one is dropped
        b = 8'($urandom);
        bus_wr(4'd0, {24'b0, b}, n0);
        sent.push_back(b);
        for (int i = 0; i < 17; i++) begin
            b = 8'($urandom);
            bus_wr(4'd0, {24'b0, b}, dummy);
            if (tx_q.size() < DEPTH) begin
                tx_q.push_back(b);
                sent.push_back(b);
            end else begin
                drop = 1;
            end
        end
        bus_rd(4'd1, rd); check("txfull_status", rd, exp_status(0));
        wait_until(n0 + 1 + 17 * 10 * DIV);
        tx_q.delete();
        for (int k = 0; k < 17; k++)
            check($sformatf("txburst_frame%0d", k), 32'(frame_bad(n0 + 1 + k * 10 * DIV, sent[k], DIV)), 32'h0);
        bus_rd(4'd1, rd); check("txburst_done_status", rd, exp_status(1));
        bus_wr(4'd1, 32'h40, dummy);
        drop = 0;
        bus_rd(4'd1, rd); check("txdrop_cleared", rd, exp_status(1));

        // RX 0xA3 then pop
        send_rx(8'hA3, DIV, 1'b1, rd);
        check("rxA3_data", rd, exp_data());
        check("rxA3_literal", rd, 32'h1A3);
        check("rxA3_intr", {31'b0, m_intr_o}, exp_intr());
        bus_wr(4'd1, 32'h1, dummy);
        void'(rx_q.pop_front());
        bus_rd(4'd0, rd); check("rx_pop_data", rd, exp_data());
        check("rx_pop_intr", {31'b0, m_intr_o}, exp_intr());

        // 17 frames into an un-popped FIFO
        for (int i = 0; i < 17; i++) begin
            send_rx(8'($urandom), DIV, 1'b1, rd);
            check($sformatf("rxfill_data%0d", i), rd, exp_data());
        end
        bus_rd(4'd1, rd); check("rxfull_status", rd, exp_status(1));
        for (int i = 0; i < DEPTH; i++) begin
            bus_rd(4'd0, rd); check($sformatf("rxdrain%0d", i), rd, exp_data());
            bus_wr(4'd1, 32'h1, dummy);
            void'(rx_q.pop_front());
        end
        bus_wr(4'd1, 32'h10, dummy);
        ovr = 0;
        bus_rd(4'd1, rd); check("rxovr_cleared", rd, exp_status(1));

        // Framing error, glitch, recovery
        send_rx(8'($urandom), DIV, 1'b1, rd);
        send_rx(8'($urandom), DIV, 1'b0, rd);
        bus_rd(4'd1, rd); check("ferr_status", rd, exp_status(1));
        RXD = 1'b0; tick(10); RXD = 1'b1; tick(100);
        bus_rd(4'd1, rd); check("glitch_ignored", rd, exp_status(1));
        send_rx(8'($urandom), DIV, 1'b1, rd);
        check("rx_after_ferr_data", rd, exp_data());
        bus_wr(4'd1, 32'h20, dummy);
        ferr = 0;
        bus_rd(4'd1, rd); check("ferr_cleared", rd, exp_status(1));

        // BAUD change mid-frame: takes effect on the following frame
        b = 8'($urandom);
        bus_wr(4'd0, {24'b0, b}, n);
        tick(100);
        bus_wr(4'd3, 32'h2, dummy);
        bus_rd(4'd3, rd); check("baud_clamped", rd, 32'h4);
        sent.delete();
        sent.push_back(b);
        sent.push_back(8'($urandom));
        bus_wr(4'd0, {24'b0, sent[1]}, dummy);
        wait_until(n + 1 + 10 * DIV + 10 * 4);
        check("baud_old_frame", 32'(frame_bad(n + 1, sent[0], DIV)), 32'h0);
        check("baud_new_frame", 32'(frame_bad(n + 1 + 10 * DIV, sent[1], 4)), 32'h0);
        bus_rd(4'd1, rd); check("baud_idle_status", rd, exp_status(1));

        // Millisecond counter boundary
        wait_until(rel + 47998);
        bus_rd(4'd2, rd); check("ms_before_tick", rd, 32'((cyc - rel + 1) / 48000));
        tick(1);
        bus_rd(4'd2, rd); check("ms_after_tick", rd, 32'((cyc - rel + 1) / 48000));
        check("ms_one", rd, 32'h1);

        // Reset in the middle of a frame
        bus_wr(4'd0, 32'h0F, dummy);
        bus_wr(4'd0, 32'hF0, dummy);
        tick(15);
        rstn = 1'b0;
        tick(1);
        rx_q.delete(); tx_q.delete();
        ovr = 0; ferr = 0; drop = 0;
        check("rst_mid_txd", {31'b0, TXD}, 32'h1);
        bus_rd(4'd1, rd); check("rst_mid_status", rd, exp_status(1));
        bus_rd(4'd3, rd); check("rst_mid_baud", rd, 32'(DIV));
        bus_rd(4'd2, rd); check("rst_mid_ms", rd, 32'h0);
        check("rst_mid_intr", {31'b0, m_intr_o}, exp_intr());
        rstn = 1'b1;
        tick(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
